// File: rtl/delta_pkg.sv
// delta_pkg: shared constants, FSM state and event type for the delta-spike link
package delta_pkg;
  localparam int DELTA_WIDTH = 8;
  localparam int DELTA_THRESHOLD = 50;
  typedef enum logic [1:0] {IDLE, APPLY, LEAK} state_t;
  typedef struct packed {
    logic                   sign;
    logic [DELTA_WIDTH-1:0] mag;
  } delta_evt_t;
endpackage

// File: rtl/delta_spike_decoder_if.sv
// delta_spike_decoder_if: valid/ready delta-event stream into the decoder
interface delta_spike_decoder_if
  import delta_pkg::*;
#(
  parameter int WIDTH = DELTA_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic             in_sign;
  logic [WIDTH-1:0] in_mag;
  modport master(output in_valid, in_mag, in_sign, input in_ready);
  modport slave(input in_valid, in_mag, in_sign, output in_ready);
endinterface

// File: rtl/delta_event_fifo.sv
// delta_event_fifo: synchronous power-of-two FIFO holding delta events
module delta_event_fifo
  import delta_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = delta_evt_t
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  T                       din,
  output T                       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  T mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign dout  = mem[rd_ptr];
  assign full  = level == LW'(DEPTH);
  assign empty = level == '0;
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= din;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(push) - LW'(pop);
    end
  end
endmodule

// File: rtl/delta_spike_decoder.sv
// delta_spike_decoder: integrates buffered delta events into a saturating reconstructed state
// Define DELTA_DEC_LEAK_EN to compile in the idle-time leak of recon toward 0.
module delta_spike_decoder
  import delta_pkg::*;
#(
  parameter int WIDTH       = DELTA_WIDTH,
  parameter int DEPTH       = 4,
  parameter int THRESHOLD   = DELTA_THRESHOLD,
  parameter int LEAK_PERIOD = 16,
  parameter int LEAK_SHIFT  = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  delta_spike_decoder_if.slave   evt,
  input  logic                   clr_flags,
  output logic [WIDTH-1:0]       recon,
  output logic                   recon_valid,
  output logic                   sat_flag,
  output logic                   err_flag,
  output logic [$clog2(DEPTH):0] fifo_level
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [WIDTH-1:0] THR = WIDTH'(THRESHOLD);
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
    $error("DEPTH must be a power of two >= 2");
  end
  if (LEAK_PERIOD < 2 || LEAK_SHIFT < 1 || LEAK_SHIFT >= WIDTH) begin : g_chk_leak
    $error("LEAK_PERIOD must be >= 2 and LEAK_SHIFT within 1..WIDTH-1");
  end
  state_t state;
  delta_evt_t din, head;
  logic full, empty, push, pop, legal, ovf, nonempty_next, leak_go;
  logic [WIDTH:0] sum, diff;
  logic [WIDTH-1:0] upd;
  assign evt.in_ready  = !full;
  assign push          = evt.in_valid && !full;
  assign pop           = state == APPLY && !empty;
  assign din           = '{sign: evt.in_sign, mag: evt.in_mag};
  assign nonempty_next = push || fifo_level > LW'(1);
  delta_event_fifo #(.DEPTH(DEPTH), .T(delta_evt_t)) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .pop  (pop),
    .din  (din),
    .dout (head),
    .full (full),
    .empty(empty),
    .level(fifo_level)
  );
  // One extra bit catches both overflow above 2^WIDTH-1 and borrow below 0.
  assign sum   = {1'b0, recon} + {1'b0, head.mag};
  assign diff  = {1'b0, recon} - {1'b0, head.mag};
  assign legal = head.mag >= THR;
  assign ovf   = head.sign ? diff[WIDTH] : sum[WIDTH];
  assign upd   = head.sign ? (diff[WIDTH] ? '0 : diff[WIDTH-1:0])
                           : (sum[WIDTH] ? '1 : sum[WIDTH-1:0]);
`ifdef DELTA_DEC_LEAK_EN
  localparam int CW = $clog2(LEAK_PERIOD);
  logic [CW-1:0] idle_cnt;
  logic [WIDTH-1:0] leak_step;
  assign leak_step = recon >> LEAK_SHIFT;
  // A push landing on the leak point wins; the leak waits for a fresh idle period.
  assign leak_go = state == IDLE && empty && !push && idle_cnt == CW'(LEAK_PERIOD - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idle_cnt <= '0;
    else idle_cnt <= (state == IDLE && !push && !leak_go) ? idle_cnt + 1'b1 : '0;
  end
`else
  assign leak_go = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      recon       <= '0;
      recon_valid <= 1'b0;
      sat_flag    <= 1'b0;
      err_flag    <= 1'b0;
    end else begin
      state       <= leak_go ? LEAK : nonempty_next ? APPLY : IDLE;
      recon_valid <= 1'b0;
      if (pop && legal) begin
        recon       <= upd;
        recon_valid <= 1'b1;
      end
`ifdef DELTA_DEC_LEAK_EN
      else if (state == LEAK && leak_step != '0) begin
        recon       <= recon - leak_step;
        recon_valid <= 1'b1;
      end
`endif
      sat_flag <= (pop && legal && ovf) || (sat_flag && !clr_flags);
      err_flag <= (pop && !legal) || (err_flag && !clr_flags);
    end
  end
endmodule

// File: tb/tb_delta_spike_decoder.sv
// tb_delta_spike_decoder: randomized and directed checks against a queue-based reference model
module tb_delta_spike_decoder;
  import delta_pkg::*;
  localparam int W = 8;
  localparam int D = 4;
  localparam int THR = 50;
  typedef struct {bit s; int m;} ev_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic clr_flags = 1'b0;
  logic [W-1:0] recon;
  logic recon_valid, sat_flag, err_flag;
  logic [$clog2(D):0] fifo_level;
  int n_cmp = 0;
  int n_bad = 0;
  int m_recon;
  bit m_valid, m_sat, m_err;
  ev_t q[$];
  delta_spike_decoder_if #(.WIDTH(W)) ifc ();
  delta_spike_decoder #(.WIDTH(W), .DEPTH(D), .THRESHOLD(THR)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .evt        (ifc),
    .clr_flags  (clr_flags),
    .recon      (recon),
    .recon_valid(recon_valid),
    .sat_flag   (sat_flag),
    .err_flag   (err_flag),
    .fifo_level (fifo_level)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic compare_all();
    chk("recon", recon, m_recon);
    chk("recon_valid", recon_valid, m_valid);
    chk("sat_flag", sat_flag, m_sat);
    chk("err_flag", err_flag, m_err);
    chk("fifo_level", fifo_level, q.size());
    chk("in_ready", ifc.in_ready, q.size() < D);
  endtask
  // One clock: check current outputs, drive inputs, advance the model by one edge.
  task automatic step(input bit v, input bit s, input int m, input bit c);
    ev_t e;
    int r;
    bit acc, set_sat, set_err;
    compare_all();
    ifc.in_valid = v;
    ifc.in_sign = s;
    ifc.in_mag = m[W-1:0];
    clr_flags = c;
    acc = v && q.size() < D;
    set_sat = 0;
    set_err = 0;
    m_valid = 0;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.m < THR) set_err = 1;
      else begin
        r = e.s ? m_recon - e.m : m_recon + e.m;
        if (r > 255) begin r = 255; set_sat = 1; end
        else if (r < 0) begin r = 0; set_sat = 1; end
        m_recon = r;
        m_valid = 1;
      end
    end
    if (acc) q.push_back('{s, m});
    m_sat = set_sat || (m_sat && !c);
    m_err = set_err || (m_err && !c);
    @(posedge clk);
    @(negedge clk);
    ifc.in_valid = 1'b0;
    clr_flags = 1'b0;
  endtask
  task automatic do_reset();
    #2 rst_n = 1'b0;
    ifc.in_valid = 1'b0;
    clr_flags = 1'b0;
    m_recon = 0;
    m_valid = 0;
    m_sat = 0;
    m_err = 0;
    q.delete();
    #1 compare_all();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    int gap;
    int k;
    ifc.in_valid = 1'b0;
    ifc.in_sign = 1'b0;
    ifc.in_mag = '0;
    @(negedge clk);
    do_reset();
    step(1, 0, 60, 0);
    chk("t1_no_early_pulse", recon_valid, 0);
    step(0, 0, 0, 0);
    chk("t1_recon60", recon, 60);
    chk("t1_pulse", recon_valid, 1);
    step(1, 1, 50, 0);
    step(0, 0, 0, 0);
    chk("t1_recon10", recon, 10);
    step(1, 0, 200, 0);
    step(1, 0, 100, 0);
    step(0, 0, 0, 0);
    chk("t2_recon255", recon, 255);
    chk("t2_sat", sat_flag, 1);
    step(1, 1, 255, 0);
    step(1, 1, 60, 0);
    step(0, 0, 0, 0);
    chk("t2_recon0", recon, 0);
    step(0, 0, 0, 0);
    chk("t2_sat_sticky", sat_flag, 1);
    step(0, 0, 0, 1);
    chk("t2_sat_cleared", sat_flag, 0);
    step(1, 0, 49, 0);
    step(0, 0, 0, 0);
    chk("t3_recon_kept", recon, 0);
    chk("t3_no_pulse", recon_valid, 0);
    chk("t3_err", err_flag, 1);
    step(1, 0, 50, 0);
    step(0, 0, 0, 0);
    chk("t3_recon50", recon, 50);
    step(0, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      step(1, i[0], 60 + i * 7, 0);
      chk("t4_ready", ifc.in_ready, 1);
    end
    step(1, 0, 90, 0);
    do_reset();
    chk("t4_rst_recon", recon, 0);
    chk("t4_rst_level", fifo_level, 0);
    step(1, 0, 80, 0);
    step(0, 0, 0, 0);
    chk("t5_recon80", recon, 80);
`ifdef DELTA_DEC_LEAK_EN
    k = 1;
    while (k <= 40) begin
      @(posedge clk);
      @(negedge clk);
      if (recon_valid) break;
      k++;
    end
    chk("leak_time", k, 17);
    chk("leak_val", recon, 70);
    m_recon = 70;
    repeat (15) begin
      @(posedge clk);
      @(negedge clk);
    end
    m_valid = 0;
    step(1, 0, 50, 0);
    step(0, 0, 0, 0);
    chk("leak_prio", recon, 120);
`else
    k = 0;
    repeat (100) step(0, 0, 0, 0);
    chk("hold_recon80", recon, 80);
`endif
    do_reset();
    gap = 0;
    repeat (300) begin
      bit v;
      int m;
      v = gap >= 3 || $urandom_range(0, 3) != 0;
      gap = v ? 0 : gap + 1;
      m = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 49)) : int'($urandom_range(50, 255));
      step(v, 1'($urandom_range(0, 1)), m, $urandom_range(0, 15) == 0);
    end
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
